// File: rtl/i2c_cmd_sequencer.sv
`timescale 1ns/1ps
// i2c_cmd_sequencer
// Command front end for the I2C EEPROM master. Write/read requests are queued
// in a small FIFO and issued one at a time on the master's newd/wr/addr/wdata
// interface. The sequencer holds them stable for the whole transaction, waits
// for the master's done pulse (or a timeout), and returns one response per
// command on a valid/ready channel.
//
// Ports
//   clk, rst_n                      system clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = FIFO not full)
//   cmd_wr, cmd_addr, cmd_wdata     command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_wr, rsp_rdata, rsp_err      response fields (rdata 0 for writes/errors)
//   m_newd, m_wr, m_addr, m_wdata   request to the I2C master
//   m_rdata, m_done                 master read data and done (async to clk)
//   busy                            FSM active or FIFO non-empty
//   fifo_count                      FIFO occupancy
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued command and a free response slot
// ISSUE     | load m_* from FIFO head, pop, raise m_newd, clear timer
// WAIT_DONE | m_newd high; wait for done_rise or timer == TIMEOUT-1
// RESP      | wait for the response slot, then present rsp_*
// DRAIN     | wait for synchronised done to fall before the next command
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [6:0]                   cmd_addr,
  input  logic [7:0]                   cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_wr,
  output logic [7:0]                   rsp_rdata,
  output logic                         rsp_err,
  output logic                         m_newd,
  output logic                         m_wr,
  output logic [6:0]                   m_addr,
  output logic [7:0]                   m_wdata,
  input  logic [7:0]                   m_rdata,
  input  logic                         m_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [7:0]      cap_rdata;
  logic            cap_err;

  // m_done synchroniser and edge detect
  logic done_meta, done_s, done_s_d1, done_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
      done_s_d1 <= 1'b0;
    end else begin
      done_meta <= m_done;
      done_s    <= done_meta;
      done_s_d1 <= done_s;
    end
  end

  assign done_rise = done_s & ~done_s_d1;

  // Command FIFO
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          run;
  logic          push, pop;
  logic [15:0]   head;

  // run keeps cmd_ready low while reset is asserted so every output reads 0
  assign cmd_ready  = run & (count != CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state == S_ISSUE);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != S_IDLE) | (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      cap_rdata <= '0;
      cap_err   <= 1'b0;
      m_newd    <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // consumer handshake; RESP below may reload in the same cycle
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // An unclaimed response still counts as outstanding, so the next
          // command waits for it to be taken.
          if (count != '0 && !rsp_valid) state <= S_ISSUE;
        end

        S_ISSUE: begin
          m_wr    <= head[15];
          m_addr  <= head[14:8];
          m_wdata <= head[7:0];
          m_newd  <= 1'b1;
          timer   <= '0;
          state   <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          timer <= timer + TW'(1);
          if (done_rise) begin
            m_newd    <= 1'b0;
            cap_rdata <= m_wr ? 8'h00 : m_rdata;
            cap_err   <= 1'b0;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            m_newd    <= 1'b0;
            cap_rdata <= 8'h00;
            cap_err   <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (!rsp_valid || rsp_ready) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= m_wr;
            rsp_rdata <= cap_rdata;
            rsp_err   <= cap_err;
            state     <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // done is a long SCL-domain pulse; let it fall so it is not
          // mistaken for the next command's completion
          if (!done_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
